// File: rtl/fp_pkg.sv
// Shared constants, state encoding and helpers for the single-precision divider.
package fp_pkg;

    localparam int unsigned BIAS  = 127;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned QBITS = 25;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned REM_W = MAN_W + 2;
    localparam int unsigned SIG_W = MAN_W + 1;
    localparam int unsigned XEXP_W = EXP_W + 2;

    localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fpdiv_state_t;

    // Signed zero or signed infinity.
    function automatic logic [31:0] fp_special(input logic sign, input logic inf);
        return inf ? {sign, FP_INF_MAG} : {sign, 31'h0};
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface fp_div_seq_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] out;

    modport master (
        output start, a, b,
        input  busy, done, out
    );

    modport slave (
        input  start, a, b,
        output busy, done, out
    );

endinterface

// File: rtl/fp_div_step.sv
// One radix-2 restoring division step: conditional subtract, then shift left.
module fp_div_step
    import fp_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [SIG_W-1:0] mb,
    output logic [REM_W-1:0] next_rem,
    output logic             qbit
);

    logic [REM_W-1:0] mb_ext;
    logic [REM_W-1:0] diff;
    logic [REM_W-1:0] kept;

    always_comb begin
        mb_ext   = {1'b0, mb};
        diff     = rem - mb_ext;
        qbit     = (rem >= mb_ext);
        kept     = qbit ? diff : rem;
        next_rem = kept << 1;
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider, one quotient bit per clock,
// with truncating normalisation and exponent clamping.
module fp_div_seq #(
    parameter int unsigned BIAS  = 127,
    parameter int unsigned QBITS = 25
) (
    input logic        clk,
    input logic        rst_n,
    fp_div_seq_if.slave bus
);

    import fp_pkg::*;

    fpdiv_state_t            state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [REM_W-1:0]        rem, rem_d;
    logic [QBITS-1:0]        q, q_d;
    logic [SIG_W-1:0]        mb, mb_d;
    logic signed [XEXP_W-1:0] exp_q, exp_d;
    logic                    sign, sign_d;
    logic                    zinf, zinf_d;
    logic                    busy, busy_d;
    logic                    done, done_d;
    logic [31:0]             out, out_d;

    logic                    step_qbit;
    logic [REM_W-1:0]        step_rem;
    logic                    take;
    logic                    a_zero, b_zero;
    logic signed [XEXP_W-1:0] e_fin;
    logic [MAN_W-1:0]        man;
    logic [31:0]             norm_out;

    fp_div_step u_step (
        .rem      (rem),
        .mb       (mb),
        .next_rem (step_rem),
        .qbit     (step_qbit)
    );

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.out  = out;

    // Normalise the quotient, truncate, and clamp the exponent range.
    always_comb begin
        man   = q[24] ? q[23:1] : q[22:0];
        e_fin = q[24] ? exp_q : exp_q - 10'sd1;
        if (e_fin <= 10'sd0) begin
            norm_out = fp_special(sign, 1'b0);
        end else if (e_fin >= 10'sd255) begin
            norm_out = fp_special(sign, 1'b1);
        end else begin
            norm_out = {sign, e_fin[EXP_W-1:0], man};
        end
    end

    // A DONE cycle that already carries the done pulse is the completion
    // cycle, so back-to-back requests land without a dead cycle.
    always_comb begin
        a_zero = ~|bus.a[30:0];
        b_zero = ~|bus.b[30:0];
        take   = bus.start && ((state == IDLE) || ((state == DONE) && done));
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rem_d   = rem;
        q_d     = q;
        mb_d    = mb;
        exp_d   = exp_q;
        sign_d  = sign;
        zinf_d  = zinf;
        busy_d  = busy;
        done_d  = 1'b0;
        out_d   = out;

        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
            end
            DIV: begin
                rem_d = step_rem;
                q_d   = {q[QBITS-2:0], step_qbit};
                cnt_d = cnt + 5'd1;
                if (cnt == CNT_W'(QBITS - 1)) begin
                    cnt_d   = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                out_d   = norm_out;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (done) begin
                    busy_d = 1'b0;
                end else begin
                    out_d  = fp_special(sign, zinf);
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            sign_d = bus.a[31] ^ bus.b[31];
            exp_d  = XEXP_W'({2'b00, bus.a[30:23]}) - XEXP_W'({2'b00, bus.b[30:23]})
                     + XEXP_W'(BIAS);
            mb_d   = {1'b1, bus.b[22:0]};
            rem_d  = REM_W'({1'b1, bus.a[22:0]});
            q_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            zinf_d = !a_zero;
            state_d = (a_zero || b_zero) ? DONE : DIV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            q     <= '0;
            mb    <= '0;
            exp_q <= '0;
            sign  <= 1'b0;
            zinf  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= 32'h0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rem   <= rem_d;
            q     <= q_d;
            mb    <= mb_d;
            exp_q <= exp_d;
            sign  <= sign_d;
            zinf  <= zinf_d;
            busy  <= busy_d;
            done  <= done_d;
            out   <= out_d;
        end
    end

endmodule
